// File: rtl/data_bus_pkg.sv
// data_bus_pkg: shared address map, status bit positions and UART state
// encoding for the data_bus block and its UART transmitter.
package data_bus_pkg;

    // Peripheral window: 16 bytes at 0x1000_0000; bits [3:2] select the register.
    localparam logic [31:0] PERIPH_BASE = 32'h1000_0000;
    localparam logic [31:0] PERIPH_MASK = 32'hFFFF_FFF0;

    // Register offsets inside the peripheral window (addr[1:0] forced to zero).
    localparam logic [3:0] OFF_LED       = 4'h0;
    localparam logic [3:0] OFF_CYCLE     = 4'h4;
    localparam logic [3:0] OFF_UART_DATA = 4'h8;
    localparam logic [3:0] OFF_UART_STAT = 4'hC;

    // UART_STAT bit positions.
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_FULL_BIT = 1;

    // Depth of the optional transmit queue.
    localparam int TX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // True when the byte address falls inside the peripheral window.
    function automatic logic is_periph(input logic [31:0] addr);
        return (addr & PERIPH_MASK) == PERIPH_BASE;
    endfunction

endpackage

// File: rtl/data_bus_uart_tx.sv
// uart_tx: 8N1 LSB-first serial transmitter with baud counter and bit index.
// Build option DATA_BUS_TX_FIFO_EN inserts a 4-entry byte queue ahead of the
// FSM; without it a byte offered while busy is dropped and full mirrors busy.
module uart_tx
    import data_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       full,
    output logic       busy,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    uart_state_t   state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    bit_idx_reg;
    logic [7:0]    shift_reg;

    logic       pending;       // a byte is waiting to be framed
    logic [7:0] pending_byte;
    logic       take;          // FSM consumes the pending byte this cycle
    logic       bit_done;      // last clock of the current bit period

    assign bit_done = (cnt_reg == CNT_LAST);
    assign take     = pending && ((state_reg == IDLE) || ((state_reg == STOP) && bit_done));

`ifdef DATA_BUS_TX_FIFO_EN
    localparam int PW = $clog2(TX_FIFO_DEPTH);

    logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          push;

    assign full         = (count_reg == (PW+1)'(TX_FIFO_DEPTH));
    assign push         = tx_valid && !full;
    assign pending      = (count_reg != '0);
    assign pending_byte = fifo_mem[rd_ptr_reg];
    assign busy         = (state_reg != IDLE) || pending;

    // Queue storage: written on accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= tx_byte;
        end
    end

    // Queue pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (take) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, take})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
`else
    // Single-byte path: only an idle transmitter accepts a byte.
    assign busy         = (state_reg != IDLE);
    assign full         = busy;
    assign pending      = tx_valid && !busy;
    assign pending_byte = tx_byte;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: each bit lasts CLKS_PER_BIT cycles.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:  if (take) state_next = START;
            START: if (bit_done) state_next = DATA;
            DATA:  if (bit_done && (bit_idx_reg == 3'd7)) state_next = STOP;
            STOP:  if (bit_done) state_next = take ? START : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Baud counter, bit index and shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else if (take) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= pending_byte;
        end else if (state_reg != IDLE) begin
            if (bit_done) begin
                cnt_reg <= '0;
                if (state_reg == DATA) begin
                    shift_reg   <= shift_reg >> 1;
                    bit_idx_reg <= bit_idx_reg + 3'd1;
                end
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    // Line level per state; idle and stop hold the line high.
    always_comb begin
        tx = 1'b1;
        unique case (state_reg)
            START:   tx = 1'b0;
            DATA:    tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_bus.sv
// data_bus: decodes cpu data accesses to data RAM or to the peripheral block
// (LED register, free-running cycle counter, UART transmitter). Reads are
// combinational; writes commit on the rising edge with mem_wr_sig_i high.
// Build option DATA_BUS_TX_FIFO_EN adds a 4-entry queue in front of the UART.
module data_bus
    import data_bus_pkg::*;
#(
    parameter int RAM_WORDS    = 1024,
    parameter int LED_W        = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      mem_addr_i,
    input  logic [31:0]      mem_wr_data_i,
    input  logic             mem_wr_sig_i,
    output logic [31:0]      mem_rd_data_o,
    output logic [LED_W-1:0] leds_o,
    output logic             uart_tx_o,
    output logic             uart_busy_o
);

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]      ram [RAM_WORDS];
    logic [LED_W-1:0] leds_reg;
    logic [31:0]      cycle_reg;

    logic          ram_hit;
    logic          periph_hit;
    logic [AW-1:0] ram_idx;
    logic [3:0]    offset;
    logic          ram_we, led_we, cycle_we, uart_we;
    logic          uart_busy, uart_full;

    // Address decode; the two low byte-address bits never matter.
    assign ram_hit    = (mem_addr_i[31:AW+2] == '0);
    assign ram_idx    = mem_addr_i[AW+1:2];
    assign periph_hit = is_periph(mem_addr_i);
    assign offset     = {mem_addr_i[3:2], 2'b00};

    assign ram_we   = mem_wr_sig_i && ram_hit;
    assign led_we   = mem_wr_sig_i && periph_hit && (offset == OFF_LED);
    assign cycle_we = mem_wr_sig_i && periph_hit && (offset == OFF_CYCLE);
    assign uart_we  = mem_wr_sig_i && periph_hit && (offset == OFF_UART_DATA);

    // Data RAM: word writes, asynchronous read, contents not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= mem_wr_data_i;
        end
    end

    // LED register keeps the low LED_W bits of the written word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds_reg <= '0;
        end else if (led_we) begin
            leds_reg <= mem_wr_data_i[LED_W-1:0];
        end
    end

    // Cycle counter: a write wins over the increment in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_reg <= '0;
        end else if (cycle_we) begin
            cycle_reg <= mem_wr_data_i;
        end else begin
            cycle_reg <= cycle_reg + 32'd1;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .tx_byte  (mem_wr_data_i[7:0]),
        .tx_valid (uart_we),
        .full     (uart_full),
        .busy     (uart_busy),
        .tx       (uart_tx_o)
    );

    // Read mux: zero for unmapped addresses and write-only registers.
    always_comb begin
        mem_rd_data_o = '0;
        if (ram_hit) begin
            mem_rd_data_o = ram[ram_idx];
        end else if (periph_hit) begin
            unique case (offset)
                OFF_LED:   mem_rd_data_o = 32'(leds_reg);
                OFF_CYCLE: mem_rd_data_o = cycle_reg;
                OFF_UART_STAT: begin
                    mem_rd_data_o[STAT_BUSY_BIT] = uart_busy;
                    mem_rd_data_o[STAT_FULL_BIT] = uart_full;
                end
                default:   mem_rd_data_o = '0;
            endcase
        end
    end

    assign leds_o      = leds_reg;
    assign uart_busy_o = uart_busy;

endmodule

// File: tb/tb_data_bus.sv
// tb_data_bus: directed checks of data_bus with CLKS_PER_BIT=4. Expectations
// follow the single-byte UART unless DATA_BUS_TX_FIFO_EN is defined.
module tb_data_bus;

    localparam int CPB = 4;
    localparam logic [31:0] A_LED   = 32'h1000_0000;
    localparam logic [31:0] A_CYCLE = 32'h1000_0004;
    localparam logic [31:0] A_UDATA = 32'h1000_0008;
    localparam logic [31:0] A_USTAT = 32'h1000_000C;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  leds;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    data_bus #(
        .RAM_WORDS    (1024),
        .LED_W        (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .mem_addr_i    (addr),
        .mem_wr_data_i (wdata),
        .mem_wr_sig_i  (we),
        .mem_rd_data_o (rdata),
        .leds_o        (leds),
        .uart_tx_o     (tx),
        .uart_busy_o   (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("pass %s 0x%08h", tag, got);
        end else begin
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One-cycle word write, committed at the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        we = 1'b0; addr = a;
        #1 d = rdata;
    endtask

    // Reference 8N1 frame: index 0 start, 1..8 data LSB first, 9 stop.
    function automatic logic frame_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return b[n-1];
    endfunction

    // Wait for a start bit and decode one frame by mid-bit sampling.
    task automatic rx_frame(output logic [7:0] b, output logic ok);
        ok = 1'b0;
        b  = '0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (tx == 1'b0) ok = 1'b1;
        end
        if (ok) begin
            for (int s = 1; s < 40; s++) begin
                @(negedge clk);
                if (s >= 6 && s <= 34 && (s % 4) == 2) b[(s-6)/4] = tx;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        ok;
        logic        txs [81];
        int          busy_cnt;
        logic        busy_end;
        logic [31:0] stat_mid;
        logic [3:0]  v;
        logic [7:0]  exp2;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rd(A_LED, r);         check("reset_led_read", r, 32'h0);
        check("reset_tx", tx, 1'b1);
        check("reset_busy", busy, 1'b0);

        // Activity, then asynchronous reset mid-frame.
        wr(A_LED, 32'h3C);    check("led_pre_reset", leds, 8'h3C);
        wr(A_UDATA, 32'h00);
        repeat (6) @(negedge clk);
        check("tx_mid_frame", tx, 1'b0);
        check("busy_mid_frame", busy, 1'b1);
        #3 reset_n = 1'b0;
        addr = A_USTAT;
        #1;
        check("midreset_leds", leds, 8'h00);
        check("midreset_tx", tx, 1'b1);
        check("midreset_busy", busy, 1'b0);
        check("midreset_stat", rdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(A_CYCLE, r);
        check("cycle_after_reset_le2", (r <= 32'd2), 1'b1);
        repeat (5) @(negedge clk);
        check("no_tx_after_reset", {31'b0, tx}, 32'h1);
        check("no_busy_after_reset", busy, 1'b0);

        // ---------------- RAM ----------------
        wr(32'h0000_0010, 32'hDEADBEEF);
        wr(32'h0000_0FFC, 32'h12345678);
        rd(32'h0000_0010, r); check("ram_0x10", r, 32'hDEADBEEF);
        rd(32'h0000_0FFC, r); check("ram_top_word", r, 32'h12345678);
        rd(32'h0000_0013, r); check("ram_byte_offset_ignored", r, 32'hDEADBEEF);
        rd(32'h0000_1000, r); check("past_ram_reads_zero", r, 32'h0);

        // ---------------- LED / unmapped ----------------
        wr(A_LED, 32'hFFFF_FFA5);
        check("leds_out", leds, 8'hA5);
        rd(A_LED, r);         check("led_read_zext", r, 32'h0000_00A5);
        wr(32'h2000_0000, 32'h1234_5678);
        wr(32'h2000_0010, 32'h1111_1111);
        rd(32'h2000_0000, r); check("unmapped_read", r, 32'h0);
        check("leds_after_unmapped", leds, 8'hA5);
        rd(32'h0000_0010, r); check("ram_no_alias", r, 32'hDEADBEEF);
        rd(32'h1000_0010, r); check("past_periph_zero", r, 32'h0);
        rd(A_UDATA, r);       check("uart_data_reads_zero", r, 32'h0);

        // ---------------- CYCLE wrap ----------------
        wr(A_CYCLE, 32'hFFFF_FFFE);
        rd(A_CYCLE, r);       check("cycle_after_1", r, 32'hFFFF_FFFF);
        @(negedge clk);
        rd(A_CYCLE, r);       check("cycle_wrap_after_3", r, 32'h0000_0001);

        // ---------------- UART + consecutive writes ----------------
        @(negedge clk); addr = A_LED;   wdata = 32'h5A;  we = 1'b1;
        @(negedge clk); addr = A_CYCLE; wdata = 32'h100;
        @(negedge clk); addr = A_UDATA; wdata = 32'h55;
        @(negedge clk); we = 1'b0; addr = A_CYCLE;
        #1;
        check("consec_cycle", rdata, 32'h101);
        check("consec_leds", leds, 8'h5A);

        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            if (tx == 1'b0) ok = 1'b1;
            else begin @(negedge clk); #1; end
        end
        check("uart_start_seen", ok, 1'b1);

        busy_cnt = 0;
        busy_end = 1'b1;
        stat_mid = '0;
        for (int k = 0; k <= 80; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            txs[k] = tx;
            if (k < 80) busy_cnt += int'(busy);
            else busy_end = busy;
            if (k == 20) stat_mid = rdata;
            if (k == 8) begin addr = A_UDATA; wdata = 32'hA3; we = 1'b1; end
            if (k == 9) begin we = 1'b0; addr = A_USTAT; end
        end

        for (int n = 0; n < 10; n++) begin
            v = {txs[4*n+3], txs[4*n+2], txs[4*n+1], txs[4*n]};
            check($sformatf("frame1_bit%0d", n), v, frame_bit(8'h55, n) ? 4'hF : 4'h0);
        end
`ifdef DATA_BUS_TX_FIFO_EN
        exp2 = 8'hA3;
        check("stat_mid_frame", stat_mid, 32'h1);
        check("busy_cycles", busy_cnt, 80);
`else
        exp2 = 8'hFF;
        check("stat_mid_frame", stat_mid, 32'h3);
        check("busy_cycles", busy_cnt, 40);
`endif
        for (int n = 0; n < 10; n++) begin
            v = {txs[40+4*n+3], txs[40+4*n+2], txs[40+4*n+1], txs[40+4*n]};
`ifdef DATA_BUS_TX_FIFO_EN
            check($sformatf("frame2_bit%0d", n), v, frame_bit(exp2, n) ? 4'hF : 4'h0);
`else
            check($sformatf("dropped_idle%0d", n), v, exp2[0] ? 4'hF : 4'h0);
`endif
        end
        check("busy_after_frames", busy_end, 1'b0);
        check("tx_after_frames", txs[80], 1'b1);

`ifdef DATA_BUS_TX_FIFO_EN
        // ---------------- FIFO fill ----------------
        begin
            logic [7:0] got [5];
            logic       got_ok [5];
            int         lows;
            fork
                begin
                    for (int i = 0; i < 6; i++) begin
                        @(negedge clk);
                        addr = A_UDATA; wdata = 32'h10 + i; we = 1'b1;
                    end
                    @(negedge clk);
                    we = 1'b0; addr = A_USTAT;
                    #1 check("fifo_stat_full", rdata, 32'h3);
                end
                begin
                    for (int f = 0; f < 5; f++) begin
                        rx_frame(got[f], got_ok[f]);
                    end
                end
            join
            for (int f = 0; f < 5; f++) begin
                check($sformatf("fifo_frame%0d_seen", f), got_ok[f], 1'b1);
                check($sformatf("fifo_frame%0d_byte", f), got[f], 8'h10 + f);
            end
            lows = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (tx == 1'b0) lows++;
            end
            check("fifo_sixth_dropped", lows, 0);
            check("fifo_idle_busy", busy, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
